// File: rtl/verdict_pkg.sv
// Shared types and constants for the verdict serializer: FSM state encoding,
// drop-counter width and the index-width helper.
package verdict_pkg;

  localparam int DROP_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  // Index width for n streams; a single stream still gets a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/verdict_fifo.sv
// Single-clock frame FIFO with registered read data. A push into a full FIFO
// is accepted when a pop happens on the same edge.
module verdict_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = rdata_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    rdata_d  = do_pop ? mem_q[rd_ptr_q[AW-1:0]] : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: rtl/verdict_serializer.sv
// Captures active monitor-output cycles as frames and drains them as one word per
// active stream. Define VERDICT_TS_EN to add the per-frame cycle timestamp.
module verdict_serializer
  import verdict_pkg::*;
#(
  parameter int  NUM_OUTPUTS = 4,
  parameter int  DATA_W      = 64,
  parameter int  FIFO_DEPTH  = 16,
  parameter int  TS_W        = 32,
  localparam int IDX_W       = idx_w(NUM_OUTPUTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_OUTPUTS*DATA_W-1:0] out_data,
  input  logic [NUM_OUTPUTS-1:0]        out_aktv,
  output logic                          v_valid,
  input  logic                          v_ready,
  output logic [IDX_W-1:0]              v_idx,
  output logic [DATA_W-1:0]             v_data,
  output logic [TS_W-1:0]               v_ts,
  output logic                          v_last,
  output logic                          overflow,
  output logic [DROP_W-1:0]             drop_cnt,
  output state_e                        dbg_state
);

  typedef struct packed {
    logic [NUM_OUTPUTS-1:0]             mask;
    logic [NUM_OUTPUTS-1:0][DATA_W-1:0] data;
`ifdef VERDICT_TS_EN
    logic [TS_W-1:0]                    ts;
`endif
  } frame_t;

  frame_t wr_frame, rd_frame;
  logic   push, pop, full, empty, drop;

  state_e                             state_q, state_d;
  logic [NUM_OUTPUTS-1:0]             mask_q, mask_d, low_bit;
  logic [NUM_OUTPUTS-1:0][DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]                   sel_idx;
  logic                               one_left;
  logic                               overflow_q, overflow_d;
  logic [DROP_W-1:0]                  drop_cnt_q, drop_cnt_d;
`ifdef VERDICT_TS_EN
  logic [TS_W-1:0]                    ts_q, ts_d, fts_q, fts_d;
`endif

  assign push = en && (|out_aktv);
  assign drop = push && full && !pop;

  always_comb begin
    wr_frame      = '0;
    wr_frame.mask = out_aktv;
    wr_frame.data = out_data;
`ifdef VERDICT_TS_EN
    wr_frame.ts   = ts_q;
`endif
  end

  verdict_fifo #(
    .WIDTH ($bits(frame_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_frame),
    .rdata (rd_frame),
    .full  (full),
    .empty (empty)
  );

  // Lowest pending stream is emitted first; the frame ends when one bit is left.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_OUTPUTS - 1; i >= 0; i--) begin
      if (mask_q[i]) sel_idx = IDX_W'(i);
    end
  end

  assign low_bit  = mask_q & (~mask_q + NUM_OUTPUTS'(1));
  assign one_left = (mask_q != '0) && ((mask_q & (mask_q - NUM_OUTPUTS'(1))) == '0);

  // v_valid/v_ready: a word transfers on a rising edge where both are high;
  // while v_valid && !v_ready every v_* output holds its value.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    data_d  = data_q;
    pop     = 1'b0;
`ifdef VERDICT_TS_EN
    fts_d   = fts_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        mask_d  = rd_frame.mask;
        data_d  = rd_frame.data;
`ifdef VERDICT_TS_EN
        fts_d   = rd_frame.ts;
`endif
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (v_ready) begin
          mask_d = mask_q & ~low_bit;
          if (one_left) begin
            if (!empty) begin
              pop     = 1'b1;
              state_d = ST_LOAD;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q | drop;
    drop_cnt_d = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + DROP_W'(1) : drop_cnt_q;
`ifdef VERDICT_TS_EN
    ts_d       = en ? ts_q + TS_W'(1) : ts_q;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
`ifdef VERDICT_TS_EN
      ts_q       <= '0;
      fts_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef VERDICT_TS_EN
      ts_q       <= ts_d;
      fts_q      <= fts_d;
`endif
    end
  end

  assign v_valid   = (state_q == ST_EMIT);
  assign v_idx     = v_valid ? sel_idx : '0;
  assign v_data    = v_valid ? data_q[sel_idx] : '0;
  assign v_last    = v_valid && one_left;
`ifdef VERDICT_TS_EN
  assign v_ts      = v_valid ? fts_q : '0;
`else
  assign v_ts      = '0;
`endif
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_verdict_serializer.sv
// Self-checking bench for verdict_serializer: directed scenarios plus randomized
// traffic against a frame-level word model.
module tb_verdict_serializer;
  import verdict_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 64;
  localparam int TW    = 32;
  localparam int DEPTH = 16;
  localparam int IW    = 2;
  localparam int W     = IW + DW + TW + 1;

  logic            clk, rst, en, v_ready, v_valid, v_last, overflow;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]    out_aktv;
  logic [IW-1:0]   v_idx;
  logic [DW-1:0]   v_data;
  logic [TW-1:0]   v_ts;
  logic [15:0]     drop_cnt;
  state_e          dbg_state;

  verdict_serializer #(
    .NUM_OUTPUTS (N),
    .DATA_W      (DW),
    .FIFO_DEPTH  (DEPTH),
    .TS_W        (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .out_data  (out_data),
    .out_aktv  (out_aktv),
    .v_valid   (v_valid),
    .v_ready   (v_ready),
    .v_idx     (v_idx),
    .v_data    (v_data),
    .v_ts      (v_ts),
    .v_last    (v_last),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int unsigned  ts_m = 0;
  int           hs_cnt = 0;
  int           frames_in = 0;
  int           frames_out = 0;
  int unsigned  hs_cyc[$];

  function automatic logic [W-1:0] mk_word(input int idx, input logic [DW-1:0] d,
                                           input logic [TW-1:0] ts, input bit last);
    return {IW'(idx), d, ts, last};
  endfunction

  // A frame yields one word per set mask bit, ascending; the highest set bit is last.
  task automatic model_capture(input logic [N-1:0] mask, input logic [N*DW-1:0] d);
    logic [TW-1:0] ts;
    int            top_bit;
`ifdef VERDICT_TS_EN
    ts = TW'(ts_m);
`else
    ts = '0;
`endif
    top_bit = -1;
    for (int i = 0; i < N; i++) if (mask[i]) top_bit = i;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) exp_q.push_back(mk_word(i, d[i*DW +: DW], ts, i == top_bit));
    end
    frames_in++;
  endtask

  function automatic logic [N*DW-1:0] rand_data();
    logic [N*DW-1:0] r;
    for (int i = 0; i < N * DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic e, input logic [N-1:0] aktv, input logic [N*DW-1:0] d,
                       input bit keep = 1'b1);
    en       = e;
    out_aktv = aktv;
    out_data = d;
    if (e && (aktv != '0) && keep) model_capture(aktv, d);
    if (e) ts_m++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, '0, rand_data());
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      idle(1);
      k++;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k;
    k = 0;
    while (!v_valid && k < budget) begin
      idle(1);
      k++;
    end
    check_eq(tag, v_valid, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, v_valid, 1'b0);
    check_eq({tag, "_idx"}, v_idx, '0);
    check_eq({tag, "_data"}, v_data, '0);
    check_eq({tag, "_ts"}, v_ts, '0);
    check_eq({tag, "_last"}, v_last, 1'b0);
    check_eq({tag, "_ovf"}, overflow, 1'b0);
    check_eq({tag, "_drop"}, drop_cnt, '0);
    check_eq({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] prev_w, cur_w;
    bit           prev_stall;
    prev_stall = 1'b0;
    prev_w     = '0;
    forever begin
      @(negedge clk);
      cur_w = {v_idx, v_data, v_ts, v_last};
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_eq("hold_valid", v_valid, 1'b1);
          check_eq("hold_word", cur_w, prev_w);
        end
        if (v_valid && v_ready) begin
          hs_cnt++;
          hs_cyc.push_back(cyc);
          check_eq("word_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) check_eq("word", cur_w, exp_q.pop_front());
          if (v_last) frames_out++;
        end
        prev_stall = v_valid && !v_ready;
        prev_w     = cur_w;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N*DW-1:0] d;
    int              h0;
    int unsigned     c0;

    // 1. reset held with all streams active
    rst = 1'b0; en = 1'b1; out_aktv = 4'b1111; out_data = rand_data(); v_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    en = 1'b0; out_aktv = '0;
    rst = 1'b1;
    ts_m = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check_eq("rst_no_valid", v_valid, 1'b0);
    end

    // 2. single frame, first word two cycles after capture
    v_ready = 1'b1;
    d = rand_data();
    d[0*DW +: DW] = 64'd1;
    d[2*DW +: DW] = 64'd3;
    drive(1'b1, 4'b0101, d);
    check_eq("lat_n0", v_valid, 1'b0);
    idle(1);
    check_eq("lat_n1", v_valid, 1'b0);
    idle(1);
    check_eq("lat_n2", v_valid, 1'b1);
    check_eq("lat_idx", v_idx, 2'd0);
    check_eq("lat_data", v_data, 64'd1);
    drain("single_drain", 20);

    // 3. backpressure on a single-word frame holding a negative value
    v_ready = 1'b0;
    d = rand_data();
    d[3*DW +: DW] = 64'hFFFF_FFFF_FFFF_FFF9;
    drive(1'b1, 4'b1000, d);
    wait_valid("bp_valid", 10);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_idx", v_idx, 2'd3);
      check_eq("bp_data", v_data, 64'hFFFF_FFFF_FFFF_FFF9);
      check_eq("bp_last", v_last, 1'b1);
      idle(1);
    end
    h0 = hs_cnt;
    v_ready = 1'b1;
    idle(3);
    check_eq("bp_one_hs", hs_cnt - h0, 1);
    check_eq("bp_done", v_valid, 1'b0);
    check_eq("bp_queue", exp_q.size(), 0);

    // 4. back-to-back single-word frames, one bubble between frames
    h0 = hs_cyc.size();
    for (int i = 0; i < 3; i++) begin
      d = rand_data();
      d[0 +: DW] = DW'(7 + i);
      drive(1'b1, 4'b0001, d);
    end
    drain("b2b_drain", 30);
    check_eq("b2b_count", hs_cyc.size() - h0, 3);
    if (hs_cyc.size() - h0 == 3) begin
      check_eq("b2b_gap1", hs_cyc[h0+1] - hs_cyc[h0], 2);
      check_eq("b2b_gap2", hs_cyc[h0+2] - hs_cyc[h0+1], 2);
    end

    // 5. overflow: one frame sits in the frame register, sixteen fill the FIFO
    v_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 4'($urandom_range(1, 15)), rand_data(), i < 17);
    end
    check_eq("ovf_flag", overflow, 1'b1);
    check_eq("ovf_cnt", drop_cnt, 16'd1);
    v_ready = 1'b1;
    drain("ovf_drain", 200);
    check_eq("ovf_sticky", overflow, 1'b1);

    // 6. en=0: no capture and no timestamp advance
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 4'b1111, rand_data());
      check_eq("en0_no_valid", v_valid, 1'b0);
    end
    drive(1'b1, 4'b0010, rand_data());
    drain("en0_after", 20);

    // 7. randomized traffic with random backpressure, occupancy kept below FIFO depth
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] m;
      v_ready = ($urandom_range(0, 9) < 7);
      m = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      if (frames_in - frames_out >= 8) m = '0;
      drive($urandom_range(0, 9) != 0, m, rand_data());
    end
    v_ready = 1'b1;
    drain("rand_drain", 300);
    check_eq("rand_ovf", overflow, 1'b1);
    check_eq("rand_drop", drop_cnt, 16'd1);
    check_eq("rand_frames", frames_out, frames_in);

    // 8. reset in the middle of a stalled frame discards everything
    v_ready = 1'b0;
    drive(1'b1, 4'b0110, rand_data());
    drive(1'b1, 4'b1001, rand_data());
    wait_valid("mid_valid", 10);
    rst = 1'b0;
    exp_q.delete();
    ts_m = 0;
    frames_in = 0;
    frames_out = 0;
    #1;
    check_reset_outputs("mid_rst");
    en = 1'b1; out_aktv = 4'b1111;
    @(posedge clk);
    #1;
    en = 1'b0; out_aktv = '0;
    rst = 1'b1;
    v_ready = 1'b1;
    h0 = hs_cnt;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check_eq("mid_no_valid", v_valid, 1'b0);
    end
    check_eq("mid_no_hs", hs_cnt - h0, 0);
    c0 = cyc;
    drive(1'b1, 4'b1010, rand_data());
    drain("mid_drain", 20);
    check_eq("mid_frames", frames_out, 1);
    check_eq("mid_quick", (cyc - c0) < 10, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
